seq_block_compare_ctrl: RTL and testbench

//  Sequencer that reuses one NBITS-wide equality comparator to compare two word streams of programmable length.
//  On start it accepts len word pairs over a valid/ready handshake and compares each pair.
//  It counts mismatches, records the index of the first mismatch and reports a block-level equal/not-equal verdict.

---
 rtl/seq_cmp_pkg.sv | 15 +
 rtl/word_eq_cmp.sv | 13 +
 rtl/seq_block_compare_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_block_compare_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared types and default sizes for the sequential block comparator.
package seq_cmp_pkg;

    // Default word width and length/index/counter width.
    localparam int NBITS_DEFAULT = 16;
    localparam int LEN_W_DEFAULT = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/word_eq_cmp.sv
// Single shared NBITS-wide equality comparator (purely combinational).
module word_eq_cmp #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             eq
);

    // Word equality.
    assign eq = (a == b);

endmodule

// File: rtl/seq_block_compare_ctrl.sv
// Sequencer that streams len word pairs through one equality comparator and
// reports a block verdict, the mismatch count and the first mismatch index.
// Optional feature macro: SEQ_CMP_EARLY_EXIT_EN -- when defined, the block ends
// on the first mismatching beat (mismatch_cnt = 1, remaining words not consumed).
module seq_block_compare_ctrl
    import seq_cmp_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [NBITS-1:0] a_word,
    input  logic [NBITS-1:0] b_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [LEN_W-1:0] mismatch_cnt,
    output logic [LEN_W-1:0] first_idx
);

    cmp_state_t       state_r;
    cmp_state_t       state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx_r;
    logic             word_eq_s;
    logic             beat_s;
    logic             mis_s;
    logic             last_s;
    logic             stop_s;

    word_eq_cmp #(
        .NBITS (NBITS)
    ) u_word_eq_cmp (
        .a  (a_word),
        .b  (b_word),
        .eq (word_eq_s)
    );

    assign beat_s = in_valid && in_ready;
    assign mis_s  = !word_eq_s;
    assign last_s = (idx_r == (len_r - LEN_W'(1)));

`ifdef SEQ_CMP_EARLY_EXIT_EN
    // Block ends on the last beat or on the first mismatching beat.
    assign stop_s = last_s || mis_s;
`else
    // Block ends only on the last beat; every pair is consumed.
    assign stop_s = last_s;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (beat_s && stop_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b0;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Block length, beat index and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_r        <= {LEN_W{1'b0}};
            idx_r        <= {LEN_W{1'b0}};
            equal        <= 1'b1;
            mismatch_cnt <= {LEN_W{1'b0}};
            first_idx    <= {LEN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r        <= len;
                        idx_r        <= {LEN_W{1'b0}};
                        equal        <= 1'b1;
                        mismatch_cnt <= {LEN_W{1'b0}};
                        first_idx    <= {LEN_W{1'b0}};
                    end
                end
                RUN: begin
                    if (beat_s) begin
                        idx_r <= idx_r + LEN_W'(1);
                        if (mis_s) begin
                            mismatch_cnt <= mismatch_cnt + LEN_W'(1);
                            // Only the first mismatch of the block records its index.
                            if (equal) begin
                                first_idx <= idx_r;
                                equal     <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    len_r <= len_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_block_compare_ctrl.sv
// Scoreboard bench for seq_block_compare_ctrl: expected block results are
// computed from the word arrays and queued at start; a monitor pops and
// compares them whenever done pulses.
module tb_seq_block_compare_ctrl;

    localparam int NBITS = 16;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [NBITS-1:0] a_word;
    logic [NBITS-1:0] b_word;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             equal;
    logic [LEN_W-1:0] mismatch_cnt;
    logic [LEN_W-1:0] first_idx;

    seq_block_compare_ctrl #(.NBITS(NBITS), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .len          (len),
        .a_word       (a_word),
        .b_word       (b_word),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_cnt (mismatch_cnt),
        .first_idx    (first_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int eq;
        int cnt;
        int first;
        int beats;
    } exp_t;

    exp_t             sb_q[$];
    logic [NBITS-1:0] a_mem [256];
    logic [NBITS-1:0] b_mem [256];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the pairs in order as the block rules describe.
    function automatic exp_t model(input int n);
        exp_t e;
        e.eq = 1; e.cnt = 0; e.first = 0; e.beats = n;
        for (int i = 0; i < n; i++) begin
            if (a_mem[i] != b_mem[i]) begin
                e.cnt++;
                if (e.eq == 1) begin
                    e.eq = 0;
                    e.first = i;
                end
`ifdef SEQ_CMP_EARLY_EXIT_EN
                e.beats = i + 1;
                break;
`endif
            end
        end
        return e;
    endfunction

    // Monitor: counts accepted beats and checks results on each done pulse.
    initial begin
        int   beats_seen;
        logic prev_done;
        exp_t e;
        beats_seen = 0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                beats_seen = 0;
                prev_done  = 1'b0;
            end else begin
                if (done) begin
                    check("done_single_cycle", prev_done, 0);
                    if (sb_q.size() == 0) begin
                        check("done_without_start", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("equal", equal, e.eq);
                        check("mismatch_cnt", mismatch_cnt, e.cnt);
                        check("first_idx", first_idx, e.first);
                        check("beats_accepted", beats_seen, e.beats);
                    end
                    beats_seen = 0;
                end
                if (in_valid && in_ready) beats_seen++;
                prev_done = done;
            end
        end
    end

    // mode: 0 valid held high, 1 random valid, 2 pattern 1,0,0,1,0,1.
    // abort >= 0: pulse reset after that many beats. poke: start pulses in RUN and DONE.
    task automatic run_block(input int n, input int mode, input int abort,
                             input bit poke, output int lat);
        exp_t e;
        int   k;
        int   cyc;
        int   pi;
        logic v;
        logic pend;
        bit   vpat [6];
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        e = model(n);
        sb_q.push_back(e);
        start    = 1'b1;
        len      = LEN_W'(n);
        in_valid = 1'b1;                 // ignored outside RUN
        a_word   = 16'hDEAD;
        b_word   = 16'hBEEF;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, (n != 0) ? 1 : 0);
        if (n == 0) check("no_ready_len0", in_ready, 0);
        k = 0; cyc = 1; pi = 0;
        while (!done && cyc < 4000) begin
            if (abort >= 0 && k == abort) begin
                reset_n  = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                sb_q.delete();
                check("abort_busy", busy, 0);
                check("abort_ready", in_ready, 0);
                check("abort_equal", equal, 1);
                check("abort_cnt", mismatch_cnt, 0);
                lat = cyc;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = vpat[pi % 6];
            endcase
            pi++;
            if (k >= n) v = 1'b0;
            in_valid = v;
            a_word   = a_mem[k % 256];
            b_word   = b_mem[k % 256];
            start    = (poke && (cyc == 2)) ? 1'b1 : 1'b0;
            len      = LEN_W'(1);
            pend     = v && in_ready;
            @(posedge clk); #1;
            if (pend) k++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("done_within_budget", done, 1);
        lat = cyc;
        if (poke) begin
            start = 1'b1;
            len   = LEN_W'(3);
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_busy", busy, 0);
            @(posedge clk); #1;
            check("start_in_done_not_queued", busy, 0);
            check("results_hold", mismatch_cnt, e.cnt);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        int n;
        reset_n  = 1'b0;
        start    = 1'b0;
        len      = '0;
        a_word   = '0;
        b_word   = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_equal", equal, 1);
        check("rst_cnt", mismatch_cnt, 0);
        check("rst_first", first_idx, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Equal block, valid held high: latency len+1.
        for (int i = 0; i < 4; i++) begin a_mem[i] = 16'(i + 1); b_mem[i] = 16'(i + 1); end
        run_block(4, 0, -1, 1'b0, lat);
        check("latency_len4", lat, 5);

        // Two mismatches at indices 1 and 3.
        b_mem[1] = 16'd9; b_mem[3] = 16'd7;
        run_block(4, 0, -1, 1'b0, lat);

        // Zero-length block.
        run_block(0, 0, -1, 1'b0, lat);
        check("latency_len0", lat, 1);

        // Gapped valid pattern.
        for (int i = 0; i < 3; i++) begin a_mem[i] = 16'(100 + i); b_mem[i] = 16'(100 + i); end
        b_mem[2] = 16'h0;
        run_block(3, 2, -1, 1'b0, lat);

        // Reset after two of five beats, then a fresh block.
        for (int i = 0; i < 5; i++) begin a_mem[i] = 16'(i); b_mem[i] = 16'(i); end
        b_mem[0] = 16'hFFFF;
        run_block(5, 0, 2, 1'b0, lat);
        a_mem[0] = 16'h1234; b_mem[0] = 16'h1234; a_mem[1] = 16'h5678; b_mem[1] = 16'h5679;
        run_block(2, 0, -1, 1'b0, lat);

        // Start pulses in RUN and DONE are ignored.
        for (int i = 0; i < 5; i++) begin a_mem[i] = 16'(i * 3); b_mem[i] = 16'(i * 3); end
        b_mem[4] = 16'h1;
        run_block(5, 1, -1, 1'b1, lat);

        // Maximum block, every pair mismatches.
        for (int i = 0; i < 255; i++) begin a_mem[i] = 16'(i); b_mem[i] = ~16'(i); end
        run_block(255, 1, -1, 1'b0, lat);

        // Random blocks.
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                a_mem[i] = 16'($urandom);
                b_mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : a_mem[i];
            end
            run_block(n, 1, -1, 1'b0, lat);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
